// File: rtl/vdff_capture_fifo_pkg.sv
// -----------------------------------------------------------------------------
// vdff_capture_fifo_pkg
// Shared constants for the delay-register capture path. The upstream delay
// stage and the capture FIFO both import this package. Width overrides then
// start from the same defaults, and the empty-queue value of out_data is
// defined in one place.
// -----------------------------------------------------------------------------
package vdff_capture_fifo_pkg;

    // Default word width, matching the upstream delay-register width.
    localparam int DEF_SIZE   = 5;
    // Default number of FIFO entries. It must be a power of two, 2..256.
    localparam int DEF_DEPTH  = 8;
    // Default pointer index width, equal to log2(DEF_DEPTH).
    localparam int DEF_ADDR_W = 3;

    // Bit value that out_data is forced to, replicated across the word,
    // whenever the queue is empty (including while in reset).
    localparam logic OUT_DATA_RST_BIT = 1'b0;

endpackage : vdff_capture_fifo_pkg

// File: rtl/vdff_fifo_ram.sv
// -----------------------------------------------------------------------------
// vdff_fifo_ram
// Register-array storage for the capture FIFO. Writes are synchronous and
// reads are combinational. The storage has no reset, because stale contents
// are never observed: the pointer logic masks them.
//
// Ports:
//   clk    in   write clock
//   we     in   write enable
//   waddr  in   [addr_w-1:0] write index
//   wdata  in   [0:size-1]   write word
//   raddr  in   [addr_w-1:0] read index
//   rdata  out  [0:size-1]   word at raddr (combinational)
// -----------------------------------------------------------------------------
module vdff_fifo_ram
    import vdff_capture_fifo_pkg::*;
#(
    parameter int size   = DEF_SIZE,
    parameter int depth  = DEF_DEPTH,
    parameter int addr_w = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [addr_w-1:0] waddr,
    input  logic [0:size-1]   wdata,
    input  logic [addr_w-1:0] raddr,
    output logic [0:size-1]   rdata
);

    logic [0:size-1] r_mem [depth];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule : vdff_fifo_ram

// File: rtl/vdff_capture_fifo.sv
// -----------------------------------------------------------------------------
// vdff_capture_fifo
// First-word-fall-through FIFO that captures the words emitted by the delay
// register stage. It presents them to a consumer through a valid/ready
// handshake, so the consumer can stall without data being lost.
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   flush        in   synchronous clear; overrides a same-cycle write or read
//   in_data      in   [0:size-1] word from the upstream stage
//   in_valid     in   in_data is valid
//   in_ready     out  FIFO can accept a word (not full)
//   out_data     out  [0:size-1] head-of-queue word, 0 when empty
//   out_valid    out  out_data is valid (not empty)
//   out_ready    in   consumer takes out_data this cycle
//   count        out  [addr_w:0] words stored, 0..depth
//   almost_full  out  count >= depth-1
// -----------------------------------------------------------------------------
module vdff_capture_fifo
    import vdff_capture_fifo_pkg::*;
#(
    parameter int size   = DEF_SIZE,
    parameter int depth  = DEF_DEPTH,
    parameter int addr_w = DEF_ADDR_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic [0:size-1] in_data,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [0:size-1] out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [addr_w:0] count,
    output logic            almost_full
);

    localparam logic [addr_w:0] PTR_ONE  = (addr_w+1)'(1);
    localparam logic [addr_w:0] AF_LEVEL = (addr_w+1)'(depth - 1);

    // Pointers carry one extra wrap bit above the storage index. This lets
    // full and empty be told apart without a spare entry.
    logic [addr_w:0]   r_wr_ptr;
    logic [addr_w:0]   r_rd_ptr;
    logic [addr_w:0]   r_count;

    logic              w_empty;
    logic              w_full;
    logic              w_we;
    logic              w_re;
    logic [0:size-1]   w_rdata;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[addr_w-1:0] == r_rd_ptr[addr_w-1:0]) &&
                     (r_wr_ptr[addr_w] != r_rd_ptr[addr_w]);

    // Flush wins over both handshakes, so a word offered with flush is dropped.
    assign w_we = in_valid && !w_full && !flush;
    assign w_re = out_ready && !w_empty && !flush;

    vdff_fifo_ram #(
        .size   (size),
        .depth  (depth),
        .addr_w (addr_w)
    ) u_ram (
        .clk   (clk),
        .we    (w_we),
        .waddr (r_wr_ptr[addr_w-1:0]),
        .wdata (in_data),
        .raddr (r_rd_ptr[addr_w-1:0]),
        .rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_we) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_re) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            // count tracks wr_ptr - rd_ptr. A simultaneous write and read
            // leaves it unchanged.
            if (w_we && !w_re) begin
                r_count <= r_count + PTR_ONE;
            end else if (w_re && !w_we) begin
                r_count <= r_count - PTR_ONE;
            end
        end
    end

    assign in_ready    = !w_full;
    assign out_valid   = !w_empty;
    // When empty, mask the storage read so that unreset or stale words never
    // reach the consumer.
    assign out_data    = w_empty ? {size{OUT_DATA_RST_BIT}} : w_rdata;
    assign count       = r_count;
    assign almost_full = (r_count >= AF_LEVEL);

endmodule : vdff_capture_fifo

// File: tb/tb_vdff_capture_fifo.sv
// -----------------------------------------------------------------------------
// tb_vdff_capture_fifo
// Directed bench for vdff_capture_fifo with size=5 and depth=8. The stimulus
// process drives the inputs. It pushes every word it expects the FIFO to
// accept into a queue and posts the expected status for each cycle. A
// separate monitor compares that status and pops and compares every word the
// DUT hands over.
// -----------------------------------------------------------------------------
module tb_vdff_capture_fifo;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic [4:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] count;
    logic       almost_full;

    vdff_capture_fifo dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .count       (count),
        .almost_full (almost_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard of words expected on out_data, in order.
    logic [4:0] exp_q[$];

    // Status probe posted by the stimulus and consumed by the monitor.
    int    req_id  = 0;
    string p_name  = "";
    int    p_cnt   = 0;
    bit    p_qzero = 1'b0;
    event  probe_ev;

    int errors = 0;
    int checks = 0;

    // Model of the number of words the FIFO should hold.
    int cnt = 0;

    // ------------------------------------------------------------------
    // Monitor: compares the status at each probe and checks the words
    // the DUT delivers.
    // ------------------------------------------------------------------
    initial begin
        int seen;
        logic [4:0] exp_w;
        seen = 0;
        forever begin
            @(negedge clk or probe_ev);
            if (req_id != seen) begin
                seen = req_id;
                checks++;
                if (count !== 4'(p_cnt)) begin
                    errors++;
                    $display("FAIL %s count: got %0d expected %0d", p_name, count, p_cnt);
                end
                checks++;
                if (in_ready !== (p_cnt != 8)) begin
                    errors++;
                    $display("FAIL %s in_ready: got %b expected %b", p_name, in_ready, p_cnt != 8);
                end
                checks++;
                if (out_valid !== (p_cnt != 0)) begin
                    errors++;
                    $display("FAIL %s out_valid: got %b expected %b", p_name, out_valid, p_cnt != 0);
                end
                checks++;
                if (almost_full !== (p_cnt >= 7)) begin
                    errors++;
                    $display("FAIL %s almost_full: got %b expected %b", p_name, almost_full, p_cnt >= 7);
                end
                if (p_cnt == 0) begin
                    checks++;
                    if (out_data !== 5'd0) begin
                        errors++;
                        $display("FAIL %s out_data_empty: got %b expected 00000", p_name, out_data);
                    end
                end
                if (p_qzero) begin
                    checks++;
                    if (exp_q.size() != 0) begin
                        errors++;
                        $display("FAIL %s undelivered: got %0d words left expected 0", p_name, exp_q.size());
                    end
                end
            end
            if (!clk && rst_n && !flush && out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL read_data: got %b with nothing expected", out_data);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (out_data !== exp_w) begin
                        errors++;
                        $display("FAIL read_data: got %b expected %b", out_data, exp_w);
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic probe(input string nm, input int c, input bit qz);
        p_name  = nm;
        p_cnt   = c;
        p_qzero = qz;
        req_id++;
    endtask

    // One clock cycle of stimulus. Entered at posedge+1, it returns at the
    // next posedge+1. The status posted here reflects the state after the
    // previous edge.
    task automatic step(input string nm, input bit iv, input logic [4:0] d,
                        input bit ordy, input bit fl);
        bit acc;
        bit rd;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        probe(nm, cnt, 1'b0);
        acc = iv && (cnt < 8) && !fl;
        rd  = ordy && (cnt > 0) && !fl;
        if (acc) exp_q.push_back(d);
        if (fl) begin
            exp_q.delete();
            cnt = 0;
        end else begin
            cnt = cnt + int'(acc) - int'(rd);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string nm);
        while (cnt > 0) step(nm, 1'b0, 5'd0, 1'b1, 1'b0);
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_data   = 5'd0;
        in_valid  = 1'b0;
        out_ready = 1'b0;

        // Reset, then idle.
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("reset_idle", 1'b0, 5'd0, 1'b0, 1'b0);

        // Single word.
        step("single_wr", 1'b1, 5'b10110, 1'b0, 1'b0);
        step("single_rd", 1'b0, 5'd0, 1'b1, 1'b0);
        step("single_after", 1'b0, 5'd0, 1'b0, 1'b0);

        // Reset mid-cycle with words stored takes effect without an edge.
        for (int i = 0; i < 3; i++) step("pre_reset", 1'b1, 5'(i + 3), 1'b0, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        cnt = 0;
        probe("async_reset", 0, 1'b1);
        -> probe_ev;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("post_reset", 1'b0, 5'd0, 1'b0, 1'b0);

        // Fill, offer a ninth word, then drain. Repeat to wrap the pointers.
        for (int r = 0; r < 3; r++) begin
            for (int w = 1; w <= 8; w++) step("fill", 1'b1, 5'(w), 1'b0, 1'b0);
            step("full_ninth", 1'b1, 5'd9, 1'b0, 1'b0);
            drain("drain");
            step("drained", 1'b0, 5'd0, 1'b0, 1'b0);
        end

        // Full with a simultaneous read: the read occurs but no write does.
        for (int w = 10; w < 18; w++) step("fill2", 1'b1, 5'(w), 1'b0, 1'b0);
        step("full_rd_wr", 1'b1, 5'd20, 1'b1, 1'b0);
        step("refill", 1'b1, 5'd20, 1'b0, 1'b0);
        drain("drain2");

        // Streaming with one word stored.
        step("stream_seed", 1'b1, 5'd30, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step("stream", 1'b1, 5'((i + 1) % 32), 1'b1, 1'b0);
        drain("drain3");

        // A flush drops the stored words and the word offered with it.
        for (int w = 21; w < 26; w++) step("pre_flush", 1'b1, 5'(w), 1'b0, 1'b0);
        step("flush", 1'b1, 5'd31, 1'b0, 1'b1);
        step("after_flush", 1'b0, 5'd0, 1'b0, 1'b0);
        step("post_flush_wr", 1'b1, 5'd7, 1'b0, 1'b0);
        drain("drain4");

        in_valid  = 1'b0;
        out_ready = 1'b0;
        probe("final", 0, 1'b1);
        @(negedge clk);
        @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_vdff_capture_fifo
